// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS)
//   PORT_A / PORT_B : grant index values used by mem_arb_rr and mem_arb
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin winner picker (purely combinational).
//   req[1:0] : in  - request vector, bit 0 = port A, bit 1 = port B
//   pointer  : in  - port that wins when both request
//   grant    : out - index of the winning port (only meaningful when |req)
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  output logic       grant
);

  always_comb begin
    grant = PORT_A;
    if (req[1] && req[0]) begin
      grant = pointer;
    end else if (req[1]) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates two requesters (A, B) onto one memory with a
// registered read port. One access per two cycles: the winner is latched
// in IDLE, issued to memory (ack, optional write) in ACCESS, and read
// data comes back from mem_q in the following cycle with rvalid.
//
// Ports:
//   clk, reset                      : clock, async active-high reset
//   a_/b_req, we, addr, wdata       : in  - requester side
//   a_/b_ack, rvalid, rdata         : out - requester side
//   mem_data, mem_read_addr,
//   mem_write_addr, mem_we          : out - memory command
//   mem_q                           : in  - memory registered read data
//
// Build option: define MEM_ARB_FIXED_PRIO_EN to make A always win ties
// (no priority pointer); otherwise ties are resolved round-robin.
//
// state  | meaning
// IDLE   | pick a winner if anyone requests; mem_we held low
// ACCESS | winner's ack pulses, memory write happens if requested
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_ack,
  output logic                  b_ack,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  grant;
  logic                  pick_ptr;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_ptr = PORT_A;
`else
  logic pointer;
  assign pick_ptr = pointer;
`endif

  mem_arb_rr u_rr (
    .req     ({b_req, a_req}),
    .pointer (pick_ptr),
    .grant   (grant)
  );

  // Read and write address always carry the same granted address.
  assign mem_read_addr  = mem_addr;
  assign mem_write_addr = mem_addr;
  assign a_rdata        = mem_q;
  assign b_rdata        = mem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      mem_we   <= 1'b0;
      mem_data <= '0;
      mem_addr <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      pointer  <= PORT_A;
`endif
    end else begin
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            // Outputs are registered, so everything seen during ACCESS
            // is loaded here on the IDLE->ACCESS edge.
            a_ack    <= (grant == PORT_A);
            b_ack    <= (grant == PORT_B);
            mem_we   <= (grant == PORT_B) ? b_we    : a_we;
            mem_data <= (grant == PORT_B) ? b_wdata : a_wdata;
            mem_addr <= (grant == PORT_B) ? b_addr  : a_addr;
`ifndef MEM_ARB_FIXED_PRIO_EN
            pointer  <= ~grant;
`endif
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // ack identifies the owner and mem_we the direction; a read's
          // data appears on mem_q in the next cycle, alongside rvalid.
          a_rvalid <= a_ack && !mem_we;
          b_rvalid <= b_ack && !mem_we;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the memory data word.
REQ-002 Parameter ADDR_WIDTH, default 6: width of the memory address.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_req / b_req  input  1  requester A/B access request; held high until the matching ack.
REQ-006 a_we / b_we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 a_addr / b_addr  input  ADDR_WIDTH  access address.
REQ-008 a_wdata / b_wdata  input  DATA_WIDTH  write data.
REQ-009 a_ack / b_ack  output  1  one-cycle pulse: this port's access is being issued to memory this cycle.
REQ-010 a_rvalid / b_rvalid  output  1  one-cycle pulse: a_rdata/b_rdata holds this port's read result.
REQ-011 a_rdata / b_rdata  output  DATA_WIDTH  read data, both driven from mem_q.
REQ-012 mem_data, mem_read_addr, mem_write_addr, mem_we  output  DATA_WIDTH/ADDR_WIDTH/ADDR_WIDTH/1  drive the data, read_addr, write_addr and we ports of mem.
REQ-013 mem_q  input  DATA_WIDTH  mem registered read output, valid one cycle after mem_read_addr is presented.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-015 In IDLE with at least one req high, the arbiter SHALL select a winner.
  - It SHALL register the winner's we, addr and wdata into the mem_* outputs.
  - It SHALL move to ACCESS.
REQ-016 In IDLE with no req high, it SHALL stay in IDLE with mem_we = 0.
REQ-017 In ACCESS, the arbiter SHALL:
  - assert the winner's ack for exactly that cycle;
  - hold mem_we high for that cycle only if the access is a write;
  - return to IDLE unconditionally.
REQ-018 Throughput SHALL be one access per two cycles; latency is req -> ack at 1 cycle, and ack -> rvalid at 1 cycle for reads.
REQ-019 For a read, the winner's rvalid SHALL pulse in the cycle after ack, with rdata = mem_q; writes SHALL never raise rvalid.
REQ-020 mem_read_addr and mem_write_addr SHALL both carry the granted address; mem_we SHALL be 0 in every IDLE cycle.
REQ-021 Arbitration SHALL be round-robin via a 1-bit priority pointer.
  - The pointer SHALL reset to A.
  - On each grant, the pointer SHALL move to the non-granted port.
  - With a single requester, that requester SHALL win regardless of the pointer.
REQ-022 A req dropped while in IDLE SHALL be ignored; once latched into ACCESS, the access SHALL complete even if req drops.
REQ-023 A requester keeping req high after its ack SHALL be treated as a new request in the next IDLE cycle.
REQ-024 Addresses SHALL be used unmodified, with no wrap or offset arithmetic.

Reset
REQ-025 On reset, the block SHALL set immediately (asynchronously):
  - state = IDLE and pointer = A;
  - a_ack, b_ack, a_rvalid, b_rvalid, mem_we = 0;
  - mem_data, mem_read_addr, mem_write_addr = 0.
REQ-026 Reset asserted during ACCESS SHALL abort the access: no ack, no write, and no rvalid is issued.

Configuration
REQ-027 With macro MEM_ARB_FIXED_PRIO_EN defined, A SHALL always win simultaneous requests and the pointer SHALL be omitted; when undefined, REQ-021 round-robin SHALL apply.

Structure
REQ-028 Package mem_arb_pkg SHALL hold:
  - the state enum (IDLE, ACCESS);
  - the port index constants PORT_A = 0 and PORT_B = 1.
REQ-029 Winner selection SHALL be one sub-module, mem_arb_rr: 2-way round-robin picker with inputs req[1:0] and pointer, output grant index.

Verification
REQ-030 Read timing: preload mem[5] = 0x1234; A reads 5 in cycle 0 -> a_ack in cycle 1, a_rvalid with a_rdata = 0x1234 in cycle 2.
REQ-031 Simultaneous writes after reset: A writes 0x00AA to 3 and B writes 0x00BB to 4 in the same cycle -> A acked in cycle 1, B acked in cycle 3, then mem[3] = 0x00AA and mem[4] = 0x00BB.
REQ-032 Sustained contention: both reads held for 8 cycles -> acks in order A, B, A, B on odd cycles.
REQ-033 Reset mid-access: reset during ACCESS of an A write of 0xFFFF to 7 -> mem_we falls without waiting for a clock edge, no a_ack, and mem[7] is unchanged.
REQ-034 Fixed priority: with MEM_ARB_FIXED_PRIO_EN, both reqs held -> A acked in cycles 1, 3, 5 and b_ack stays 0.
REQ-035 Write-then-read: B writes 0x5A5A to 63, then reads 63 -> b_rdata = 0x5A5A with b_rvalid.
